// File: rtl/ctrl_pkg.sv
// Shared control constants: the opcodes the main control decoder recognises,
// the field-kind encoding used on the loader stream, and the loader FSM states.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd12;
  localparam logic [5:0] OP_SUBIU = 6'd13;
  localparam logic [5:0] OP_SW    = 6'd16;
  localparam logic [5:0] OP_LW    = 6'd17;

  typedef enum logic [2:0] {
    KIND_RTYPE = 3'd0,
    KIND_ADDIU = 3'd1,
    KIND_SUBIU = 3'd2,
    KIND_SW    = 3'd3,
    KIND_LW    = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_FULL = 2'd3
  } state_e;

  function automatic logic [31:0] enc_itype(input logic [5:0]  op,
                                            input logic [4:0]  rs,
                                            input logic [4:0]  rt,
                                            input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns a decoded field beat into a 32-bit
// instruction word, flagging kinds the control decoder has no opcode for.
module instr_pack
  import ctrl_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_ADDIU: word = enc_itype(OP_ADDIU, rs, rt, imm);
      KIND_SUBIU: word = enc_itype(OP_SUBIU, rs, rt, imm);
      KIND_SW:    word = enc_itype(OP_SW, rs, rt, imm);
      KIND_LW:    word = enc_itype(OP_LW, rs, rt, imm);
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory loader: accepts field beats, packs them and writes the
// words to consecutive word addresses, one registered write per legal beat.
module instr_loader
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_kind,
  input  logic [4:0]             in_rs,
  input  logic [4:0]             in_rt,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_shamt,
  input  logic [5:0]             in_funct,
  input  logic [15:0]            in_imm,
  input  logic                   in_last,
  output logic                   im_we,
  output logic [AW-1:0]          im_addr,
  output logic [31:0]            im_wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [31:0]   pack_word;
  logic          pack_illegal;
  logic          accept;
  logic [CW-1:0] count_inc;

  instr_pack u_pack (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .funct   (in_funct),
    .imm     (in_imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        // A beat that fills memory ends in FULL even when it is also the last.
        if (accept && !pack_illegal && count_inc == FULL_CNT) state_d = ST_FULL;
        else if (accept && in_last)                           state_d = ST_DONE;
      end
      ST_DONE, ST_FULL: if (start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_LOAD) && !start;
    busy     = (state_q == ST_LOAD);
    done     = (state_q == ST_DONE) || (state_q == ST_FULL);
  end

  // Write register: the word is presented for exactly the cycle after acceptance.
  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    if (start) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      if (pack_illegal) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = AW'({count_q, 2'b00});
        wdata_d = pack_word;
        count_d = count_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign count    = count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader (DEPTH=4): directed beats, a per-cycle reference
// model of the loader's observable behaviour, and hand-computed literal checks.
module tb_instr_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic          in_last;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [CW-1:0] count;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_kind  (in_kind),
    .in_rs    (in_rs),
    .in_rt    (in_rt),
    .in_rd    (in_rd),
    .in_shamt (in_shamt),
    .in_funct (in_funct),
    .in_imm   (in_imm),
    .in_last  (in_last),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = idle, 1 = loading, 2 = finished (done or full).
  int          m_mode;
  int          m_cnt;
  bit          m_err;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;

  function automatic logic [31:0] encode(input logic [2:0] k, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn,
                                         input logic [15:0] imm);
    logic [5:0] opc;
    opc = 6'd0;
    case (k)
      3'd1: opc = 6'd12;
      3'd2: opc = 6'd13;
      3'd3: opc = 6'd16;
      3'd4: opc = 6'd17;
      default: opc = 6'd4;
    endcase
    if (k == 3'd0) return (32'(opc) << 26) | (32'(rs) << 21) | (32'(rt) << 16)
                          | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
    return (32'(opc) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_cnt   <= 0;
      m_err   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      m_we <= 1'b0;
      if (start) begin
        m_mode <= 1;
        m_cnt  <= 0;
        m_err  <= 1'b0;
      end else if (m_mode == 1 && in_valid) begin
        if (in_kind > 3'd4) begin
          m_err <= 1'b1;
          if (in_last) m_mode <= 2;
        end else begin
          m_we    <= 1'b1;
          m_addr  <= 32'(m_cnt * 4);
          m_wdata <= encode(in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm);
          m_cnt   <= m_cnt + 1;
          if (m_cnt + 1 == DEPTH || in_last) m_mode <= 2;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("im_we",    32'(im_we),    32'(m_we));
      chk("im_addr",  im_addr,       m_addr);
      chk("im_wdata", im_wdata,      m_wdata);
      chk("count",    32'(count),    32'(m_cnt));
      chk("err",      32'(err),      32'(m_err));
      chk("busy",     32'(busy),     32'(m_mode == 1));
      chk("done",     32'(done),     32'(m_mode == 2));
      chk("in_ready", 32'(in_ready), 32'((m_mode == 1) && !start));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic last);
    in_valid = 1'b1;
    in_kind  = k;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_shamt = sh;
    in_funct = fn;
    in_imm   = imm;
    in_last  = last;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(im_we),    32'd0);
    chk({tag, "_addr"},  im_addr,       32'd0);
    chk({tag, "_wdata"}, im_wdata,      32'd0);
    chk({tag, "_count"}, 32'(count),    32'd0);
    chk({tag, "_busy"},  32'(busy),     32'd0);
    chk({tag, "_done"},  32'(done),     32'd0);
    chk({tag, "_err"},   32'(err),      32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_funct = '0; in_imm = '0;
    idle();
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    cmp_en = 1'b1;

    // Single ADDIU
    pulse_start();
    beat(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 1'b0);
    step();
    idle();
    chk("addiu_we",    32'(im_we),    32'd1);
    chk("addiu_addr",  im_addr,       32'd0);
    chk("addiu_wdata", im_wdata,      32'h30220005);
    chk("addiu_count", 32'(count),    32'd1);
    step();
    chk("addiu_we_drop", 32'(im_we),  32'd0);
    chk("addiu_hold",    im_wdata,    32'h30220005);

    // RTYPE then LW with in_last, back-to-back
    pulse_start();
    beat(3'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'h21, 16'h0000, 1'b0);
    step();
    chk("rtype_wdata", im_wdata, 32'h10642821);
    chk("rtype_addr",  im_addr,  32'd0);
    beat(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0010, 1'b1);
    step();
    idle();
    chk("lw_we",    32'(im_we),    32'd1);
    chk("lw_wdata", im_wdata,      32'h44080010);
    chk("lw_addr",  im_addr,       32'd4);
    chk("lw_done",  32'(done),     32'd1);
    chk("lw_ready", 32'(in_ready), 32'd0);
    step();
    // Beats after DONE are ignored
    beat(3'd1, 5'd9, 5'd9, 5'd0, 5'd0, 6'd0, 16'h1234, 1'b0);
    step();
    step();
    idle();
    chk("done_ignore_count", 32'(count), 32'd2);

    // Illegal kind between two SUBIU beats
    pulse_start();
    beat(3'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 1'b0);
    step();
    beat(3'd6, 5'd2, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b0);
    step();
    chk("illegal_we",  32'(im_we), 32'd0);
    chk("illegal_err", 32'(err),   32'd1);
    beat(3'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0002, 1'b1);
    step();
    idle();
    chk("subiu2_addr",  im_addr,    32'd4);
    chk("subiu2_wdata", im_wdata,   32'h34210002);
    chk("subiu2_count", 32'(count), 32'd2);
    chk("subiu2_err",   32'(err),   32'd1);
    step();

    // Fill to DEPTH without in_last
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      beat(3'd3, 5'd7, 5'd6, 5'd0, 5'd0, 6'd0, 16'(i), 1'b0);
      step();
    end
    idle();
    chk("full_count", 32'(count), 32'd4);
    chk("full_done",  32'(done),  32'd1);
    chk("full_addr",  im_addr,    32'd12);
    chk("full_wdata", im_wdata,   32'h40E60003);
    step();

    // start during a stream
    pulse_start();
    beat(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 1'b0);
    step();
    beat(3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h00AA, 1'b0);
    step();
    beat(3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h00BB, 1'b0);
    start = 1'b1;
    #1;
    chk("restart_ready",  32'(in_ready), 32'd0);
    chk("restart_pend",   32'(im_we),    32'd1);
    chk("restart_paddr",  im_addr,       32'd0);
    chk("restart_perr",   32'(err),      32'd1);
    step();
    start = 1'b0;
    chk("restart_count0", 32'(count), 32'd0);
    chk("restart_err0",   32'(err),   32'd0);
    beat(3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h00CC, 1'b0);
    step();
    chk("restart_addr",  im_addr,    32'd0);
    chk("restart_count", 32'(count), 32'd1);
    chk("restart_wdata", im_wdata,   32'h302100CC);
    beat(3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h00DD, 1'b0);
    step();

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    idle();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_busy",  32'(busy),  32'd0);
    step();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
